// File: rtl/uart_hs_bridge_if.sv
// Byte handshake bundle between the UART bridge (master) and the command processor (slave).
// Carries the cmd_req/cmd_ack command channel and the rsp_req/rsp_ack response channel.
interface uart_hs_bridge_if;
    logic       uart_cmd_req;
    logic [7:0] uart_cmd_data;
    logic       uart_cmd_ack;
    logic       uart_rsp_req;
    logic [7:0] uart_rsp_data;
    logic       uart_rsp_ack;

    modport master (
        output uart_cmd_req,
        output uart_cmd_data,
        input  uart_cmd_ack,
        input  uart_rsp_req,
        input  uart_rsp_data,
        output uart_rsp_ack
    );

    modport slave (
        input  uart_cmd_req,
        input  uart_cmd_data,
        output uart_cmd_ack,
        output uart_rsp_req,
        output uart_rsp_data,
        input  uart_rsp_ack
    );
endinterface

// File: rtl/uart_hs_bridge.sv
// Bridge between UART PHY rx/tx cores and the 4-phase handshake port of the command processor.
// RX bytes are buffered in a FIFO and presented one per cmd handshake; rsp bytes drive the TX core.
module uart_hs_bridge #(
    parameter int unsigned P_RX_AW       = 4,
    parameter int unsigned P_TX_START_TO = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_ferr,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    uart_hs_bridge_if.master     hs,
    output logic [P_RX_AW:0]     o_rx_level,
    output logic [15:0]          o_rx_drop_cnt,
    output logic                 o_tx_err
);

    localparam int unsigned LP_DEPTH = 2 ** P_RX_AW;
    localparam int unsigned LP_LW    = P_RX_AW + 1;
    localparam int unsigned LP_TW    = $clog2(P_TX_START_TO + 1);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_REQ   = 2'd1;
    localparam logic [1:0] C_HOLD  = 2'd2;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_WBUSY = 2'd1;
    localparam logic [1:0] T_WDONE = 2'd2;
    localparam logic [1:0] T_ACK   = 2'd3;

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]         r_mem [LP_DEPTH];
    logic [P_RX_AW-1:0] r_wptr;
    logic [P_RX_AW-1:0] r_rptr;
    logic [P_RX_AW:0]   r_level;
    logic [15:0]        r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_pop;

    assign w_full  = (r_level == LP_LW'(LP_DEPTH));
    assign w_empty = (r_level == '0);
    // A push at full is dropped even if a pop frees a slot in the same cycle.
    assign w_push  = i_rx_valid & ~i_rx_ferr & ~w_full;
    assign w_drop  = i_rx_valid & (i_rx_ferr | w_full);

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr] <= i_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + P_RX_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_RX_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LP_LW'(1);
                2'b01:   r_level <= r_level - LP_LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------- CMD FSM
    logic [1:0] r_cmd_state;
    logic [1:0] w_cmd_state_nxt;
    logic       r_cmd_req;
    logic       w_cmd_req_nxt;
    logic [7:0] r_cmd_data;
    logic [7:0] w_cmd_data_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_state <= C_IDLE;
            r_cmd_req   <= 1'b0;
            r_cmd_data  <= '0;
        end else begin
            r_cmd_state <= w_cmd_state_nxt;
            r_cmd_req   <= w_cmd_req_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
        end
    end

    // The head byte stays in the FIFO until the consumer's ack falls, so data is stable through C_HOLD.
    always_comb begin
        w_cmd_state_nxt = r_cmd_state;
        w_cmd_req_nxt   = r_cmd_req;
        w_cmd_data_nxt  = r_cmd_data;
        w_pop           = 1'b0;
        case (r_cmd_state)
            C_IDLE: begin
                if (!w_empty) begin
                    w_cmd_data_nxt  = r_mem[r_rptr];
                    w_cmd_req_nxt   = 1'b1;
                    w_cmd_state_nxt = C_REQ;
                end
            end
            C_REQ: begin
                if (hs.uart_cmd_ack) begin
                    w_cmd_req_nxt   = 1'b0;
                    w_cmd_state_nxt = C_HOLD;
                end
            end
            C_HOLD: begin
                if (!hs.uart_cmd_ack) begin
                    w_pop           = 1'b1;
                    w_cmd_state_nxt = C_IDLE;
                end
            end
            default: begin
                w_cmd_req_nxt   = 1'b0;
                w_cmd_state_nxt = C_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- RSP FSM
    logic [1:0]       r_rsp_state;
    logic [1:0]       w_rsp_state_nxt;
    logic             r_tx_start;
    logic             w_tx_start_nxt;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_tx_data_nxt;
    logic             r_rsp_ack;
    logic             w_rsp_ack_nxt;
    logic             r_tx_err;
    logic             w_tx_err_nxt;
    logic [LP_TW-1:0] r_to_cnt;
    logic [LP_TW-1:0] w_to_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_state <= T_IDLE;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_rsp_ack   <= 1'b0;
            r_tx_err    <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_rsp_state <= w_rsp_state_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_rsp_ack   <= w_rsp_ack_nxt;
            r_tx_err    <= w_tx_err_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
        end
    end

    // A TX core that never reports busy still gets the handshake completed, flagged by tx_err.
    always_comb begin
        w_rsp_state_nxt = r_rsp_state;
        w_tx_start_nxt  = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_rsp_ack_nxt   = r_rsp_ack;
        w_tx_err_nxt    = 1'b0;
        w_to_cnt_nxt    = r_to_cnt;
        case (r_rsp_state)
            T_IDLE: begin
                if (hs.uart_rsp_req) begin
                    w_tx_data_nxt   = hs.uart_rsp_data;
                    w_tx_start_nxt  = 1'b1;
                    w_to_cnt_nxt    = '0;
                    w_rsp_state_nxt = T_WBUSY;
                end
            end
            T_WBUSY: begin
                if (i_tx_busy) begin
                    w_rsp_state_nxt = T_WDONE;
                end else if (r_to_cnt == LP_TW'(P_TX_START_TO - 1)) begin
                    w_tx_err_nxt    = 1'b1;
                    w_rsp_ack_nxt   = 1'b1;
                    w_rsp_state_nxt = T_ACK;
                end else begin
                    w_to_cnt_nxt    = r_to_cnt + LP_TW'(1);
                end
            end
            T_WDONE: begin
                if (!i_tx_busy) begin
                    w_rsp_ack_nxt   = 1'b1;
                    w_rsp_state_nxt = T_ACK;
                end
            end
            T_ACK: begin
                if (!hs.uart_rsp_req) begin
                    w_rsp_ack_nxt   = 1'b0;
                    w_rsp_state_nxt = T_IDLE;
                end
            end
            default: begin
                w_rsp_ack_nxt   = 1'b0;
                w_rsp_state_nxt = T_IDLE;
            end
        endcase
    end

    assign hs.uart_cmd_req  = r_cmd_req;
    assign hs.uart_cmd_data = r_cmd_data;
    assign hs.uart_rsp_ack  = r_rsp_ack;
    assign o_tx_start       = r_tx_start;
    assign o_tx_data        = r_tx_data;
    assign o_tx_err         = r_tx_err;
    assign o_rx_level       = r_level;
    assign o_rx_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_hs_bridge.sv
// Bench for uart_hs_bridge: queue/count model of the RX path checked every cycle,
// a 4-phase cmd responder, a TX core model and directed rsp transfers.
module tb_uart_hs_bridge;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TO    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ferr = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [AW:0] rx_level;
    logic [15:0] rx_drop_cnt;
    logic        tx_err;

    logic        ack_en = 1'b1;
    logic        resp_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic        rsp_req = 1'b0;
    logic [7:0]  rsp_data = '0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_ack_fall = 0;
    int n_pop_seen = 0;
    int n_hs = 0;
    int n_start = 0;
    int n_txerr = 0;
    int start_cyc = 0;
    int err_cyc = 0;
    int busy_len = 10;
    int m_level = 0;
    int m_drop = 0;
    bit chk_en = 1'b0;
    logic [7:0] last_tx = '0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_hs_bridge_if hs ();
    assign hs.uart_cmd_ack  = ack_en ? resp_ack : man_ack;
    assign hs.uart_rsp_req  = rsp_req;
    assign hs.uart_rsp_data = rsp_data;

    uart_hs_bridge #(.P_RX_AW(AW), .P_TX_START_TO(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_rx_ferr     (rx_ferr),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_tx_busy     (tx_busy),
        .hs            (hs),
        .o_rx_level    (rx_level),
        .o_rx_drop_cnt (rx_drop_cnt),
        .o_tx_err      (tx_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RX model: accepted bytes queue up in arrival order, a completed 4-phase handshake removes one.
    wire m_push = rx_valid && !rx_ferr && (m_level < DEPTH);
    wire m_pop  = (n_ack_fall != n_pop_seen);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_level    <= 0;
            m_drop     <= 0;
            n_pop_seen <= n_ack_fall;
            exp_q.delete();
        end else begin
            if (m_push) exp_q.push_back(rx_data);
            if (rx_valid && !m_push && m_drop < 65535) m_drop <= m_drop + 1;
            if (m_pop) n_pop_seen <= n_pop_seen + 1;
            m_level <= m_level + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("rx_level", 32'(rx_level), 32'(m_level));
                check("rx_drop_cnt", 32'(rx_drop_cnt), 32'(m_drop));
            end
        end
    end

    initial begin : responder
        logic [7:0] held;
        held = '0;
        forever begin
            @(posedge clk); #1;
            if (ack_en) begin
                if (!resp_ack && hs.uart_cmd_req) begin
                    if (exp_q.size() == 0) begin
                        fail("cmd_req_unexpected");
                    end else begin
                        check("cmd_data", 32'(hs.uart_cmd_data), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    held     = hs.uart_cmd_data;
                    resp_ack = 1'b1;
                end else if (resp_ack) begin
                    check("cmd_data_stable", 32'(hs.uart_cmd_data), 32'(held));
                    if (!hs.uart_cmd_req) begin
                        resp_ack = 1'b0;
                        n_ack_fall++;
                        n_hs++;
                    end
                end
            end
        end
    end

    initial begin : tx_monitor
        forever begin
            @(posedge clk); #1;
            if (tx_start) begin
                n_start++;
                last_tx   = tx_data;
                start_cyc = cyc;
            end
            if (tx_err) begin
                n_txerr++;
                err_cyc = cyc;
            end
        end
    end

    initial begin : tx_core
        forever begin
            @(posedge clk); #1;
            if (tx_start && busy_len > 0) begin
                logic [7:0] d;
                bit live;
                d       = tx_data;
                live    = 1'b1;
                tx_busy = 1'b1;
                for (int k = 0; k < busy_len; k++) begin
                    @(posedge clk); #1;
                    if (!rst_n) live = 1'b0;
                    if (live) check("tx_data_stable", 32'(tx_data), 32'(d));
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] d, input logic ferr);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_ferr  = ferr;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_level != 0 || hs.uart_cmd_req || resp_ack) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) fail({tag, "_drain_timeout"});
    endtask

    task automatic rsp_xfer(input logic [7:0] d, input int exp_err);
        int s0;
        int e0;
        int t;
        bit got;
        s0 = n_start;
        e0 = n_txerr;
        got = 1'b0;
        t = 0;
        @(posedge clk); #1;
        rsp_req  = 1'b1;
        rsp_data = d;
        while (!got && t < 100) begin
            @(posedge clk); #1;
            if (hs.uart_rsp_ack) got = 1'b1;
            t++;
        end
        if (!got) fail("rsp_ack_timeout");
        check("busy_low_at_ack", 32'(tx_busy), 32'(0));
        rsp_req = 1'b0;
        @(posedge clk); #1;
        check("rsp_ack_fall", 32'(hs.uart_rsp_ack), 32'(0));
        repeat (4) @(posedge clk);
        #1;
        check("tx_start_once", 32'(n_start - s0), 32'(1));
        check("tx_data", 32'(last_tx), 32'(d));
        check("tx_err_cnt", 32'(n_txerr - e0), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_req"},  32'(hs.uart_cmd_req),  32'(0));
        check({tag, "_cmd_data"}, 32'(hs.uart_cmd_data), 32'(0));
        check({tag, "_rsp_ack"},  32'(hs.uart_rsp_ack),  32'(0));
        check({tag, "_tx_start"}, 32'(tx_start),         32'(0));
        check({tag, "_tx_data"},  32'(tx_data),          32'(0));
        check({tag, "_tx_err"},   32'(tx_err),           32'(0));
        check({tag, "_level"},    32'(rx_level),         32'(0));
        check({tag, "_drop"},     32'(rx_drop_cnt),      32'(0));
    endtask

    initial begin : main
        int hs0;
        int t;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // 1) four bytes through the 4-phase responder, plus first-byte latency
        hs0 = n_hs;
        send_rx(8'h8F, 1'b0);
        check("lat_req_early", 32'(hs.uart_cmd_req), 32'(0));
        @(posedge clk); #1;
        check("lat_req", 32'(hs.uart_cmd_req), 32'(1));
        check("first_cmd_data", 32'(hs.uart_cmd_data), 32'(8'h8F));
        send_rx(8'hC7, 1'b0);
        send_rx(8'h00, 1'b0);
        send_rx(8'h01, 1'b0);
        wait_drain("t1");
        check("t1_handshakes", 32'(n_hs - hs0), 32'(4));
        check("t1_level", 32'(rx_level), 32'(0));

        // 2) overflow: 20 bytes with ack held low
        ack_en = 1'b0;
        for (int i = 0; i < 20; i++) send_rx(8'(8'h10 + i), 1'b0);
        @(posedge clk); #1;
        check("t2_level_full", 32'(rx_level), 32'(16));
        check("t2_drop", 32'(rx_drop_cnt), 32'(4));
        check("t2_head", 32'(hs.uart_cmd_data), 32'(8'h10));
        hs0 = n_hs;
        ack_en = 1'b1;
        wait_drain("t2");
        check("t2_handshakes", 32'(n_hs - hs0), 32'(16));

        // 3) framing error byte is dropped
        send_rx(8'h55, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t3_no_req", 32'(hs.uart_cmd_req), 32'(0));
        end
        check("t3_drop", 32'(rx_drop_cnt), 32'(5));
        check("t3_level", 32'(rx_level), 32'(0));

        // 4) response byte with a 10-cycle busy TX core
        busy_len = 10;
        rsp_xfer(8'hA5, 0);

        // 5) TX core never reports busy
        busy_len = 0;
        rsp_xfer(8'h3C, 1);
        check("t5_err_delay", 32'(err_cyc - start_cyc), 32'(TO));

        // 6) reset with cmd side in C_HOLD and rsp side waiting for busy to fall
        ack_en   = 1'b0;
        man_ack  = 1'b0;
        busy_len = 20;
        @(posedge clk); #1;
        rsp_req  = 1'b1;
        rsp_data = 8'h5A;
        t = 0;
        while (!tx_busy && t < 20) begin @(posedge clk); #1; t++; end
        if (!tx_busy) fail("t6_busy_timeout");
        repeat (2) @(posedge clk);
        #1;
        send_rx(8'h3C, 1'b0);
        t = 0;
        while (!hs.uart_cmd_req && t < 10) begin @(posedge clk); #1; t++; end
        check("t6_cmd_data", 32'(hs.uart_cmd_data), 32'(8'h3C));
        man_ack = 1'b1;
        t = 0;
        while (hs.uart_cmd_req && t < 10) begin @(posedge clk); #1; t++; end
        if (hs.uart_cmd_req) fail("t6_req_fall_timeout");
        check("t6_no_ack_yet", 32'(hs.uart_rsp_ack), 32'(0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst6");
        rst_n   = 1'b1;
        rsp_req = 1'b0;
        man_ack = 1'b0;
        t = 0;
        while (tx_busy && t < 40) begin @(posedge clk); #1; t++; end
        if (tx_busy) fail("t6_busy_fall_timeout");
        check("t6_no_restart", 32'(hs.uart_rsp_ack), 32'(0));
        ack_en = 1'b1;
        hs0 = n_hs;
        send_rx(8'hA1, 1'b0);
        send_rx(8'hB2, 1'b0);
        wait_drain("t6");
        check("t6_handshakes", 32'(n_hs - hs0), 32'(2));
        busy_len = 3;
        rsp_xfer(8'hC3, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
